// File: rtl/pulse_gen_pkg.sv
// pulse_gen_pkg: shared FSM states and default counter width for pulse_gen
package pulse_gen_pkg;
  localparam int CNT_W_DEF = 8;
  typedef enum logic [1:0] {IDLE, HIGH, LOW, DONE} state_t;
endpackage

// File: rtl/pg_down_cnt.sv
// pg_down_cnt: loadable down-counter with zero flag
// Ports: clk, rstn (sync, active-low), load/val (load value), dec (count down), zero (count is 0)
module pg_down_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] val,
  output logic         zero
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk)
    if (!rstn) cnt <= '0;
    else if (load) cnt <= val;
    else if (dec && cnt != '0) cnt <= cnt - 1'b1;
  assign zero = cnt == '0;
endmodule

// File: rtl/pulse_gen.sv
// pulse_gen: programmable pulse-train generator (width/gap/count), abortable
// Ports: clk, rstn (sync, active-low), start, width, gap, count, abort in;
//        pulse, busy, done registered out
module pulse_gen
  import pulse_gen_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [CNT_W-1:0] width,
  input  logic [CNT_W-1:0] gap,
  input  logic [CNT_W-1:0] count,
  input  logic             abort,
  output logic             pulse,
  output logic             busy,
  output logic             done
);
  state_t state, state_nxt;
  logic [CNT_W-1:0] width_q, gap_q, rem, ph_val;
  logic ph_load, ph_dec, ph_zero, accept;
  // phase counter holds cycles remaining after the current one, so a field of 0 behaves like 1
  function automatic logic [CNT_W-1:0] eff_m1(input logic [CNT_W-1:0] x);
    return x == '0 ? '0 : x - 1'b1;
  endfunction
  assign accept = state == IDLE && start && !abort;
  always_comb begin
    state_nxt = state;
    ph_load = 1'b0;
    ph_dec = 1'b0;
    ph_val = '0;
    if (abort) state_nxt = IDLE;
    else
      case (state)
        IDLE: if (start) begin
          state_nxt = count == '0 ? DONE : HIGH;
          ph_load = 1'b1;
          ph_val = eff_m1(width);
        end
        HIGH: if (ph_zero) begin
          state_nxt = rem == CNT_W'(1) ? DONE : LOW;
          ph_load = 1'b1;
          ph_val = eff_m1(gap_q);
        end else ph_dec = 1'b1;
        LOW: if (ph_zero) begin
          state_nxt = HIGH;
          ph_load = 1'b1;
          ph_val = eff_m1(width_q);
        end else ph_dec = 1'b1;
        default: state_nxt = IDLE;
      endcase
  end
  pg_down_cnt #(.W(CNT_W)) u_phase (
    .clk(clk), .rstn(rstn), .load(ph_load), .dec(ph_dec), .val(ph_val), .zero(ph_zero)
  );
  always_ff @(posedge clk)
    if (!rstn) begin
      state <= IDLE;
      width_q <= '0;
      gap_q <= '0;
      rem <= '0;
      pulse <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_nxt;
      pulse <= state_nxt == HIGH;
      busy <= state_nxt == HIGH || state_nxt == LOW;
      done <= state_nxt == DONE;
      if (accept) begin
        width_q <= width;
        gap_q <= gap;
        rem <= count;
      end else if (state == HIGH && ph_zero && !abort) rem <= rem - 1'b1;
    end
endmodule
